// File: rtl/sal_ddr_pkg.sv
// Shared DDR2 command definitions: command codes, pin encoding, default timings
// and the sizing helpers for the inter-bank timing counters.
package sal_ddr_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  typedef struct packed {
    logic ras_n;
    logic cas_n;
    logic we_n;
  } ddr_pins_t;

  localparam int DEF_T_RRD   = 2;
  localparam int DEF_T_CCD   = 2;
  localparam int DEF_T_WR2RD = 6;
  localparam int DEF_T_RD2WR = 4;

  localparam ddr_pins_t PINS_NOP = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

  function automatic ddr_pins_t cmd_pins(input cmd_e cmd);
    ddr_pins_t p;
    p = PINS_NOP;
    case (cmd)
      CMD_ACT: p = '{ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b1};
      CMD_RD:  p = '{ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b1};
      CMD_WR:  p = '{ras_n: 1'b1, cas_n: 1'b0, we_n: 1'b0};
      CMD_PRE: p = '{ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b0};
      default: p = PINS_NOP;
    endcase
    return p;
  endfunction

  // A counter for timing t holds at most t-1; keep at least one bit.
  function automatic int cnt_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

  function automatic int cnt_ld(input int t);
    return (t > 1) ? t - 1 : 0;
  endfunction

endpackage

// File: rtl/sal_rr_picker.sv
// One-hot request picker: rotate the request vector by the pointer, take the
// lowest set bit, and rotate the index back. Fixed mode uses a zero pointer.
module sal_rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW-1:0]  base;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;
  logic           found;

  always_comb begin
    base      = rr_mode ? ptr : '0;
    dbl       = {req, req} >> base;
    rot       = dbl[N-1:0];
    off       = '0;
    found     = 1'b0;
    grant     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PW+1)'(N))
      sum = sum - (PW+1)'(N);
    grant_idx = sum[PW-1:0];
    grant_any = found;
    if (found)
      grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/sal_cmd_arbiter.sv
// DRAM command arbiter: picks one timing-legal command per cycle from the bank
// channels and drives a registered DDR2 command bus one cycle later.
module sal_cmd_arbiter
  import sal_ddr_pkg::*;
#(
  parameter int BK_CNT    = 4,
  parameter int BA_W      = 2,
  parameter int ADDR_W    = 14,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_WR2RD   = DEF_T_WR2RD,
  parameter int T_RD2WR   = DEF_T_RD2WR,
  parameter int CAS_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_rr_mode,
  input  logic [BK_CNT-1:0]        req_valid,
  input  logic [2*BK_CNT-1:0]      req_cmd,
  input  logic [BA_W*BK_CNT-1:0]   req_ba,
  input  logic [ADDR_W*BK_CNT-1:0] req_addr,
  output logic [BK_CNT-1:0]        req_ready,
  output logic                     dfi_cs_n,
  output logic                     dfi_ras_n,
  output logic                     dfi_cas_n,
  output logic                     dfi_we_n,
  output logic [BA_W-1:0]          dfi_ba,
  output logic [ADDR_W-1:0]        dfi_addr
);

  localparam int PW      = $clog2(BK_CNT);
  localparam int RRD_W   = cnt_w(T_RRD);
  localparam int CCD_W   = cnt_w(T_CCD);
  localparam int WR2RD_W = cnt_w(T_WR2RD);
  localparam int RD2WR_W = cnt_w(T_RD2WR);

  localparam logic [RRD_W-1:0]   RRD_LD   = RRD_W'(cnt_ld(T_RRD));
  localparam logic [CCD_W-1:0]   CCD_LD   = CCD_W'(cnt_ld(T_CCD));
  localparam logic [WR2RD_W-1:0] WR2RD_LD = WR2RD_W'(cnt_ld(T_WR2RD));
  localparam logic [RD2WR_W-1:0] RD2WR_LD = RD2WR_W'(cnt_ld(T_RD2WR));

  logic [RRD_W-1:0]   rrd_cnt;
  logic [CCD_W-1:0]   ccd_cnt;
  logic [WR2RD_W-1:0] wr2rd_cnt;
  logic [RD2WR_W-1:0] rd2wr_cnt;
  logic [PW-1:0]      rr_ptr;

  logic rrd_ok, rd_ok, wr_ok;
  assign rrd_ok = (rrd_cnt == '0);
  assign rd_ok  = (ccd_cnt == '0) && (wr2rd_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rd2wr_cnt == '0);

  cmd_e              ch_cmd  [BK_CNT];
  logic [BA_W-1:0]   ch_ba   [BK_CNT];
  logic [ADDR_W-1:0] ch_addr [BK_CNT];
  logic [BK_CNT-1:0] elig, cas_elig, cand, grant;

  for (genvar gi = 0; gi < BK_CNT; gi++) begin : g_ch
    assign ch_cmd[gi]   = cmd_e'(req_cmd[2*gi +: 2]);
    assign ch_ba[gi]    = req_ba[BA_W*gi +: BA_W];
    assign ch_addr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
    assign elig[gi]     = req_valid[gi] &&
                          ((ch_cmd[gi] == CMD_ACT) ? rrd_ok :
                           (ch_cmd[gi] == CMD_RD)  ? rd_ok  :
                           (ch_cmd[gi] == CMD_WR)  ? wr_ok  : 1'b1);
    assign cas_elig[gi] = elig[gi] && (ch_cmd[gi] == CMD_RD || ch_cmd[gi] == CMD_WR);
  end

  assign cand = ((CAS_FIRST != 0) && (|cas_elig)) ? cas_elig : elig;

  logic [PW-1:0] grant_idx;
  logic          grant_any;

  sal_rr_picker #(.N(BK_CNT), .PW(PW)) u_picker (
    .req       (cand),
    .ptr       (rr_ptr),
    .rr_mode   (cfg_rr_mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The grant must vanish while reset is held, not just after the next edge.
  assign req_ready = rst ? '0 : grant;

  cmd_e sel_cmd;
  assign sel_cmd = ch_cmd[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrd_cnt   <= '0;
      ccd_cnt   <= '0;
      wr2rd_cnt <= '0;
      rd2wr_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      if (grant_any && sel_cmd == CMD_ACT)      rrd_cnt <= RRD_LD;
      else if (rrd_cnt != '0)                   rrd_cnt <= rrd_cnt - RRD_W'(1);

      if (grant_any && (sel_cmd == CMD_RD || sel_cmd == CMD_WR)) ccd_cnt <= CCD_LD;
      else if (ccd_cnt != '0)                   ccd_cnt <= ccd_cnt - CCD_W'(1);

      if (grant_any && sel_cmd == CMD_WR)       wr2rd_cnt <= WR2RD_LD;
      else if (wr2rd_cnt != '0)                 wr2rd_cnt <= wr2rd_cnt - WR2RD_W'(1);

      if (grant_any && sel_cmd == CMD_RD)       rd2wr_cnt <= RD2WR_LD;
      else if (rd2wr_cnt != '0)                 rd2wr_cnt <= rd2wr_cnt - RD2WR_W'(1);

      if (grant_any && cfg_rr_mode)
        rr_ptr <= (grant_idx == PW'(BK_CNT-1)) ? '0 : grant_idx + PW'(1);
    end
  end

  ddr_pins_t sel_pins;
  assign sel_pins = cmd_pins(sel_cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dfi_cs_n  <= 1'b1;
      dfi_ras_n <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_we_n  <= 1'b1;
      dfi_ba    <= '0;
      dfi_addr  <= '0;
    end else if (grant_any) begin
      dfi_cs_n  <= 1'b0;
      dfi_ras_n <= sel_pins.ras_n;
      dfi_cas_n <= sel_pins.cas_n;
      dfi_we_n  <= sel_pins.we_n;
      dfi_ba    <= ch_ba[grant_idx];
      dfi_addr  <= ch_addr[grant_idx];
    end else begin
      // Deselect; ba/addr keep their last values.
      dfi_cs_n  <= 1'b1;
      dfi_ras_n <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_we_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// Directed bench for sal_cmd_arbiter: hand-computed grant and DFI expectations.
module tb_sal_cmd_arbiter;

  localparam logic [3:0] P_DES = 4'b1111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_rr_mode = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_cmd = '0;
  logic [7:0]  req_ba = '0;
  logic [55:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [1:0]  dfi_ba;
  logic [13:0] dfi_addr;

  int compared = 0;
  int mismatched = 0;

  sal_cmd_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_rr_mode (cfg_rr_mode),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_ba      (req_ba),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .dfi_cs_n    (dfi_cs_n),
    .dfi_ras_n   (dfi_ras_n),
    .dfi_cas_n   (dfi_cas_n),
    .dfi_we_n    (dfi_we_n),
    .dfi_ba      (dfi_ba),
    .dfi_addr    (dfi_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [1:0] c,
                        input logic [1:0] b, input logic [13:0] a);
    req_valid[i]         = v;
    req_cmd[2*i +: 2]    = c;
    req_ba[2*i +: 2]     = b;
    req_addr[14*i +: 14] = a;
  endtask

  task automatic chk_dfi(input string tag, input logic [3:0] pins,
                         input logic [1:0] ba, input logic [13:0] addr);
    chk({tag, "_pins"}, {28'd0, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, {28'd0, pins});
    chk({tag, "_ba"},   {30'd0, dfi_ba}, {30'd0, ba});
    chk({tag, "_addr"}, {18'd0, dfi_addr}, {18'd0, addr});
  endtask

  initial begin
    // Reset held with traffic present: nothing granted, bus idle.
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 2'b11, 2'(i), 14'h3ff);
    tick();
    chk("rst_ready", {28'd0, req_ready}, 32'h0);
    chk_dfi("rst_dfi", P_DES, 2'd0, 14'h0);
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 2'b00, 2'd0, 14'h0);
    rst = 1'b0;
    tick();
    chk_dfi("post_rst_idle", P_DES, 2'd0, 14'h0);

    // ACT spacing by tRRD.
    set_ch(0, 1'b1, 2'b00, 2'd0, 14'h123);
    set_ch(1, 1'b1, 2'b00, 2'd1, 14'h456);
    settle();
    chk("act_c0_ready", {28'd0, req_ready}, 32'h1);
    tick();
    set_ch(0, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("act_c1_dfi", P_ACT, 2'd0, 14'h123);
    settle();
    chk("act_c1_rrd_block", {28'd0, req_ready}, 32'h0);
    tick();
    chk_dfi("act_c2_hold", P_DES, 2'd0, 14'h123);
    chk("act_c2_ready", {28'd0, req_ready}, 32'h2);
    tick();
    set_ch(1, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("act_c3_dfi", P_ACT, 2'd1, 14'h456);
    tick();

    // Column command preempts ACT.
    set_ch(0, 1'b1, 2'b00, 2'd0, 14'h077);
    set_ch(2, 1'b1, 2'b01, 2'd2, 14'h010);
    settle();
    chk("cas_first_ready", {28'd0, req_ready}, 32'h4);
    tick();
    set_ch(2, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("cas_first_rd", P_RD, 2'd2, 14'h010);
    settle();
    chk("cas_then_act_ready", {28'd0, req_ready}, 32'h1);
    tick();
    set_ch(0, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("cas_then_act_dfi", P_ACT, 2'd0, 14'h077);
    tick();
    tick();

    // WR then RD separated by tWR2RD.
    set_ch(1, 1'b1, 2'b10, 2'd1, 14'h020);
    settle();
    chk("wr_ready", {28'd0, req_ready}, 32'h2);
    tick();
    set_ch(1, 1'b0, 2'b00, 2'd0, 14'h0);
    set_ch(3, 1'b1, 2'b01, 2'd3, 14'h030);
    chk_dfi("wr_dfi", P_WR, 2'd1, 14'h020);
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk($sformatf("wr2rd_block_t%0d", k), {28'd0, req_ready}, 32'h0);
      tick();
    end
    settle();
    chk("wr2rd_release_t6", {28'd0, req_ready}, 32'h8);
    tick();
    set_ch(3, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("wr2rd_rd_dfi", P_RD, 2'd3, 14'h030);

    // Continuous PRE on all channels: round robin, then fixed priority.
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 2'b11, 2'(i), 14'h400 | 14'(i));
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("rr_pre_ready_%0d", k), {28'd0, req_ready}, 32'(1 << (k % 4)));
      tick();
      chk_dfi($sformatf("rr_pre_dfi_%0d", k), P_PRE, 2'(k % 4), 14'h400 | 14'(k % 4));
    end
    cfg_rr_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("fixed_pre_ready_%0d", k), {28'd0, req_ready}, 32'h1);
      tick();
      chk_dfi($sformatf("fixed_pre_dfi_%0d", k), P_PRE, 2'd0, 14'h400);
    end

    // Asynchronous reset in the middle of traffic.
    rst = 1'b1;
    settle();
    chk("async_rst_ready", {28'd0, req_ready}, 32'h0);
    chk_dfi("async_rst_dfi", P_DES, 2'd0, 14'h0);
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 2'b00, 2'd0, 14'h0);
    tick();
    rst = 1'b0;
    cfg_rr_mode = 1'b1;

    // Reset clears a pending WR-to-RD hold.
    set_ch(1, 1'b1, 2'b10, 2'd1, 14'h040);
    settle();
    chk("rst_wr_ready", {28'd0, req_ready}, 32'h2);
    tick();
    set_ch(1, 1'b0, 2'b00, 2'd0, 14'h0);
    set_ch(2, 1'b1, 2'b01, 2'd2, 14'h050);
    settle();
    chk("rst_wr2rd_5", {28'd0, req_ready}, 32'h0);
    tick();
    settle();
    chk("rst_wr2rd_4", {28'd0, req_ready}, 32'h0);
    rst = 1'b1;
    settle();
    chk("rst_hold_ready", {28'd0, req_ready}, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_rd_released", {28'd0, req_ready}, 32'h4);
    tick();
    set_ch(2, 1'b0, 2'b00, 2'd0, 14'h0);
    chk_dfi("rst_rd_dfi", P_RD, 2'd2, 14'h050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sal_cmd_arbiter.md
Name: sal_cmd_arbiter

Overview:
Parametrised DRAM command arbiter for the next-generation controller. It sits between the per-bank controllers and the DFI command pins. Each cycle it picks one legal command from BK_CNT bank request channels and enforces the shared inter-bank timing (tRRD, tCCD, write-to-read, read-to-write). It supports round-robin or fixed-priority arbitration and optional column-command-first priority, and drives a registered DDR2 command bus.

Parameters:
BK_CNT, 4, number of bank request channels (2..16)
BA_W, 2, bank address width
ADDR_W, 14, row/column address width
T_RRD, 2, min cycles ACT to ACT (any banks)
T_CCD, 2, min cycles RD/WR to RD/WR
T_WR2RD, 6, min cycles WR to RD
T_RD2WR, 4, min cycles RD to WR
CAS_FIRST, 1, 1 = RD/WR candidates preempt ACT/PRE

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins)
req_valid  in  BK_CNT  per-channel request valid
req_cmd  in  2*BK_CNT  per-channel command: 00 ACT, 01 RD, 10 WR, 11 PRE
req_ba  in  BA_W*BK_CNT  per-channel bank address
req_addr  in  ADDR_W*BK_CNT  per-channel row/column address (A10 = auto-pre/all)
req_ready  out  BK_CNT  per-channel grant, one-hot or zero
dfi_cs_n  out  1  chip select
dfi_ras_n  out  1  RAS
dfi_cas_n  out  1  CAS
dfi_we_n  out  1  WE
dfi_ba  out  BA_W  bank address
dfi_addr  out  ADDR_W  address

Behaviour:
- Reset (async on rst rise, held while rst=1):
  - req_ready=0.
  - dfi_cs_n=ras_n=cas_n=we_n=1; dfi_ba=0; dfi_addr=0.
  - All timing counters=0; rr_ptr=0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational in the same cycle, at most one bit set.
  - A channel keeps cmd/ba/addr stable while valid && !ready.
  - Dropping valid without a grant is legal.
- Eligibility of channel i:
  - ACT needs rrd_cnt==0.
  - RD needs ccd_cnt==0 && wr2rd_cnt==0.
  - WR needs ccd_cnt==0 && rd2wr_cnt==0.
  - PRE is always eligible.
- Candidate set:
  - Eligible valid channels.
  - If CAS_FIRST=1 and any eligible RD/WR exists, the set is restricted to RD/WR.
- Selection:
  - cfg_rr_mode=1: first candidate at index >= rr_ptr, wrapping BK_CNT-1 -> 0.
  - cfg_rr_mode=0: lowest candidate index.
  - cfg_rr_mode changes take effect on the same cycle's arbitration.
- rr_ptr: on a grant in RR mode, rr_ptr <= (granted+1) mod BK_CNT. Unchanged with no grant or in fixed mode.
- Output latency: exactly 1 cycle from grant to DFI pins.
  - ACT: ras_n=0, cas_n=1, we_n=1.
  - RD: ras_n=1, cas_n=0, we_n=1.
  - WR: ras_n=1, cas_n=0, we_n=0.
  - PRE: ras_n=0, cas_n=1, we_n=0.
  - All commands: cs_n=0, ba/addr from the granted channel.
  - No grant: deselect (cs_n=1, ras/cas/we=1); ba/addr hold their last values.
- Counters:
  - Each counter is ceil(log2(max+1)) bits, decrements to 0 and saturates.
  - On grant, the relevant counters load (T-1): ACT -> rrd; RD -> ccd, rd2wr; WR -> ccd, wr2rd.
  - A load in the same cycle overrides the decrement.
  - T<=1 loads 0, i.e. no blocking.
- No grant when there are no candidates. Starvation avoidance is the RR pointer only.

Decomposition:
- Package sal_ddr_pkg:
  - Command enum (ACT/RD/WR/PRE) and the DDR2 pin-encoding function.
  - Default timing constants.
  - Counter-width helper.
- Sub-module sal_rr_picker: BK_CNT-bit request vector + pointer + mode -> one-hot grant. Implemented as a double-width rotate-and-priority-encode; purely combinational, reused by the refresh arbiter.

Test Plan:
- Reset: rst=1 mid-traffic -> req_ready=0, dfi_cs_n/ras_n/cas_n/we_n=1, ba=0, addr=0 in the same cycle. Outputs stay deselected until the first grant.
- ACT on ch0 (ba=0) and ch1 (ba=1) valid at cycle 0, RR, rr_ptr=0 -> ch0 granted cycle 0, DFI ACT ba=0 at cycle 1. ch1 granted cycle 2, not cycle 1 (T_RRD=2).
- CAS_FIRST=1: ch0 ACT and ch2 RD valid together, counters 0 -> ch2 granted first, ch0 the next cycle.
- WR granted on ch1 at cycle t, RD on ch3 valid from t+1 -> RD granted at t+6 (T_WR2RD=6). DFI RD appears at t+7.
- All 4 channels present continuous PRE: RR -> grants 0,1,2,3,0 on consecutive cycles; switching cfg_rr_mode=0 -> ch0 every cycle.
- rst pulsed while wr2rd_cnt=4, pending RD on ch2 -> RD granted in the first cycle after rst deasserts.
